// File: rtl/program_loader_pkg.sv
// program_loader_pkg
// Shared definitions for the serial program loader: FSM state encoding,
// frame TYPE codes, sticky error codes and the default frame start marker.
package program_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_TYPE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_COUNT,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_WRITE,
    ST_CHECK
  } state_t;

  localparam logic [7:0] TYPE_PROG = 8'h00;
  localparam logic [7:0] TYPE_DATA = 8'h01;
  localparam logic [7:0] TYPE_RUN  = 8'hFF;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_CHECKSUM = 2'd1;
  localparam logic [1:0] ERR_FORMAT   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/program_loader_timer.sv
// inter_byte_timer
// Down-counter that flags a gap of TIMEOUT_CYCLES cycles between bytes.
//   clk_in   : clock
//   reset_n  : asynchronous active-low reset (counter to 0)
//   clear    : reload the full timeout (byte accepted or loader idle)
//   enable   : count down while a frame is in progress
//   expired  : high in the cycle whose rising edge completes the timeout
module inter_byte_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
  input  logic clk_in,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= W'(TIMEOUT_CYCLES);
    end else if (enable && count != '0) begin
      count <= count - W'(1);
    end
  end

  // Fires on the last count regardless of a coincident byte; the loader
  // lets the error win and hands that byte to IDLE.
  assign expired = enable && (count == W'(1));

endmodule

// File: rtl/program_loader.sv
// program_loader
// Receives framed bytes from a serial receiver and writes 16-bit words into
// program or data RAM, then releases the core from init on a run frame.
//   clk_in    : 50 MHz clock
//   reset_n   : asynchronous active-low reset
//   rx_data   : received byte; rx_valid/rx_ready handshake
//   mem_addr  : word address, mem_data : word, mem_sel : 0 prog / 1 data
//   mem_wren  : one-cycle write strobe
//   init_out  : 1 holds the core in init
//   load_done : one-cycle pulse on an accepted run frame
//   err_code  : sticky 0 none, 1 checksum, 2 format, 3 timeout
//
// state      | meaning
// IDLE       | hunting for SYNC, other bytes dropped
// TYPE       | frame type: prog, data or run
// ADDR_HI    | byte address high
// ADDR_LO    | byte address low
// COUNT      | word count, address/range validated here
// DATA_HI    | word high byte
// DATA_LO    | word low byte
// WRITE      | one write strobe cycle, rx_ready low
// CHECK      | checksum byte
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
  input  logic        clk_in,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_data,
  output logic        mem_sel,
  output logic        mem_wren,
  output logic        init_out,
  output logic        load_done,
  output logic [1:0]  err_code
);

  state_t      state;
  logic [7:0]  sum;
  logic [7:0]  addr_hi;
  logic [14:0] base_word;
  logic        addr_odd;
  logic [7:0]  count;
  logic [7:0]  word_idx;
  logic [7:0]  data_hi;
  logic        run_frame;

  logic        accept;
  logic        expired;
  logic [7:0]  sum_next;
  logic [15:0] last_word;
  logic        bad_count;

  assign accept   = rx_valid && rx_ready;
  assign sum_next = sum + rx_data;

  // rx_data is the COUNT byte when this is consulted.
  assign last_word = {1'b0, base_word} + {8'h00, rx_data} - 16'd1;
  assign bad_count = addr_odd || (rx_data == 8'h00) || (last_word > 16'h7FFF);

  inter_byte_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .clear   (accept || state == ST_IDLE),
    .enable  (state != ST_IDLE),
    .expired (expired)
  );

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      sum       <= '0;
      addr_hi   <= '0;
      base_word <= '0;
      addr_odd  <= 1'b0;
      count     <= '0;
      word_idx  <= '0;
      data_hi   <= '0;
      run_frame <= 1'b0;
      rx_ready  <= 1'b1;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_sel   <= 1'b0;
      mem_wren  <= 1'b0;
      init_out  <= 1'b1;
      load_done <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      mem_wren  <= 1'b0;
      load_done <= 1'b0;
      rx_ready  <= 1'b1;
      if (expired) begin
        err_code <= ERR_TIMEOUT;
        state    <= ST_IDLE;
        // Error wins: a byte in this cycle is judged as if already idle,
        // and the timeout code survives even if that byte is SYNC.
        if (accept && rx_data == SYNC_BYTE) begin
          state <= ST_TYPE;
          sum   <= '0;
        end
      end else begin
        if (accept && state != ST_IDLE) sum <= sum_next;
        case (state)
          ST_IDLE: begin
            if (accept && rx_data == SYNC_BYTE) begin
              state    <= ST_TYPE;
              sum      <= '0;
              err_code <= ERR_NONE;
            end
          end
          ST_TYPE: begin
            if (accept) begin
              case (rx_data)
                TYPE_PROG, TYPE_DATA: begin
                  mem_sel   <= rx_data[0];
                  run_frame <= 1'b0;
                  init_out  <= 1'b1;
                  state     <= ST_ADDR_HI;
                end
                TYPE_RUN: begin
                  run_frame <= 1'b1;
                  state     <= ST_CHECK;
                end
                default: begin
                  err_code <= ERR_FORMAT;
                  state    <= ST_IDLE;
                end
              endcase
            end
          end
          ST_ADDR_HI: begin
            if (accept) begin
              addr_hi <= rx_data;
              state   <= ST_ADDR_LO;
            end
          end
          ST_ADDR_LO: begin
            if (accept) begin
              base_word <= {addr_hi, rx_data[7:1]};
              addr_odd  <= rx_data[0];
              state     <= ST_COUNT;
            end
          end
          ST_COUNT: begin
            if (accept) begin
              if (bad_count) begin
                err_code <= ERR_FORMAT;
                state    <= ST_IDLE;
              end else begin
                count    <= rx_data;
                word_idx <= '0;
                state    <= ST_DATA_HI;
              end
            end
          end
          ST_DATA_HI: begin
            if (accept) begin
              data_hi <= rx_data;
              state   <= ST_DATA_LO;
            end
          end
          ST_DATA_LO: begin
            if (accept) begin
              mem_data <= {data_hi, rx_data};
              mem_addr <= base_word + 15'(word_idx);
              mem_wren <= 1'b1;
              rx_ready <= 1'b0;
              state    <= ST_WRITE;
            end
          end
          ST_WRITE: begin
            word_idx <= word_idx + 8'd1;
            state    <= (word_idx == count - 8'd1) ? ST_CHECK : ST_DATA_HI;
          end
          ST_CHECK: begin
            if (accept) begin
              if (sum_next == 8'h00) begin
                if (run_frame) begin
                  init_out  <= 1'b0;
                  load_done <= 1'b1;
                end
              end else begin
                err_code <= ERR_CHECKSUM;
              end
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  localparam int unsigned TO = 100;

  logic        clk_in = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [14:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_sel;
  logic        mem_wren;
  logic        init_out;
  logic        load_done;
  logic [1:0]  err_code;

  program_loader #(.TIMEOUT_CYCLES(TO), .SYNC_BYTE(8'hA5)) dut (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_sel   (mem_sel),
    .mem_wren  (mem_wren),
    .init_out  (init_out),
    .load_done (load_done),
    .err_code  (err_code)
  );

  always #10 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;
  int load_pulses = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic [7:0]  fb[$];
  logic [15:0] words[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe is one captured {sel, addr, data} word.
  always @(negedge clk_in) begin
    if (mem_wren === 1'b1) begin
      got_q.push_back({mem_sel, mem_addr, mem_data});
      check("rx_ready_in_write", {31'd0, rx_ready}, 32'd0);
    end
    if (load_done === 1'b1) load_pulses++;
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    repeat ($urandom_range(0, 2)) @(negedge clk_in);
    @(negedge clk_in);
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 50) check("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
    @(posedge clk_in);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame();
    foreach (fb[i]) send_byte(fb[i]);
  endtask

  // Reference model: builds the byte stream and the writes it must produce.
  task automatic build_data(input logic [7:0] typ, input logic [15:0] baddr,
                            input int cnt, input logic [7:0] chk_delta);
    logic [7:0] s;
    s = 8'h00;
    fb = {};
    fb.push_back(8'hA5);
    fb.push_back(typ);
    fb.push_back(baddr[15:8]);
    fb.push_back(baddr[7:0]);
    fb.push_back(8'(cnt));
    for (int i = 0; i < cnt; i++) begin
      fb.push_back(words[i][15:8]);
      fb.push_back(words[i][7:0]);
      exp_q.push_back({typ[0], 15'(int'(baddr[15:1]) + i), words[i]});
    end
    for (int i = 1; i < fb.size(); i++) s = s + fb[i];
    fb.push_back(8'(8'h00 - s) + chk_delta);
  endtask

  task automatic random_words(input int cnt);
    words = {};
    for (int i = 0; i < cnt; i++) words.push_back(16'($urandom));
  endtask

  task automatic compare_writes(input string tag);
    int n;
    repeat (4) @(posedge clk_in);
    #1;
    check({tag, "_write_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_write"}, got_q[i], exp_q[i]);
    got_q = {};
    exp_q = {};
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_init_out"},  {31'd0, init_out},  32'd1);
    check({tag, "_rx_ready"},  {31'd0, rx_ready},  32'd1);
    check({tag, "_mem_wren"},  {31'd0, mem_wren},  32'd0);
    check({tag, "_mem_addr"},  {17'd0, mem_addr},  32'd0);
    check({tag, "_mem_data"},  {16'd0, mem_data},  32'd0);
    check({tag, "_mem_sel"},   {31'd0, mem_sel},   32'd0);
    check({tag, "_load_done"}, {31'd0, load_done}, 32'd0);
    check({tag, "_err_code"},  {30'd0, err_code},  32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lp0;
    int cnt;
    int unsigned base;
    logic [7:0] typ;

    // Reset values
    #35;
    check_reset_vals("reset");
    @(negedge clk_in);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_in);

    // Directed program load: 0x1234 @ 8, 0xABCD @ 9
    words = {16'h1234, 16'hABCD};
    build_data(8'h00, 16'h0010, 2, 8'h00);
    send_frame();
    repeat (4) @(posedge clk_in);
    #1;
    if (got_q.size() == 2) begin
      check("prog_word0", got_q[0], 32'h0008_1234);
      check("prog_word1", got_q[1], 32'h0009_ABCD);
    end
    compare_writes("prog");
    check("prog_err", {30'd0, err_code}, 32'd0);
    check("prog_init", {31'd0, init_out}, 32'd1);

    // Run frame
    lp0 = load_pulses;
    fb = {8'hA5, 8'hFF, 8'h01};
    send_frame();
    check("run_init_low", {31'd0, init_out}, 32'd0);
    check("run_load_done", {31'd0, load_done}, 32'd1);
    repeat (4) @(posedge clk_in);
    #1;
    check("run_pulse_count", load_pulses - lp0, 32'd1);
    check("run_err", {30'd0, err_code}, 32'd0);

    // Random valid frames (first one re-asserts init)
    for (int k = 0; k < 6; k++) begin
      cnt  = $urandom_range(1, 4);
      base = $urandom_range(0, 32'h7FFF - cnt + 1);
      typ  = 8'($urandom_range(0, 1));
      random_words(cnt);
      build_data(typ, 16'(base << 1), cnt, 8'h00);
      send_frame();
      compare_writes("rand");
      check("rand_err", {30'd0, err_code}, 32'd0);
      check("rand_init", {31'd0, init_out}, 32'd1);
    end

    // Top-of-RAM boundary: words 0x7FFE..0x7FFF is legal
    random_words(2);
    build_data(8'h01, 16'hFFFC, 2, 8'h00);
    send_frame();
    compare_writes("top");
    check("top_err", {30'd0, err_code}, 32'd0);

    // Range overflow, odd address, zero count: format error, no writes
    fb = {8'hA5, 8'h01, 8'hFF, 8'hFE, 8'h02};
    send_frame();
    compare_writes("range");
    check("range_err", {30'd0, err_code}, 32'd2);
    fb = {8'hA5, 8'h00, 8'h00, 8'h11, 8'h01};
    send_frame();
    compare_writes("odd");
    check("odd_err", {30'd0, err_code}, 32'd2);
    fb = {8'hA5, 8'h00, 8'h00, 8'h10, 8'h00};
    send_frame();
    compare_writes("zero");
    check("zero_err", {30'd0, err_code}, 32'd2);

    // Bad checksum: writes still land, err 1, init stays high
    random_words(3);
    build_data(8'h00, 16'h0100, 3, 8'h01);
    send_frame();
    compare_writes("badchk");
    check("badchk_err", {30'd0, err_code}, 32'd1);
    check("badchk_init", {31'd0, init_out}, 32'd1);
    send_byte(8'hA5);
    check("sync_clears_err", {30'd0, err_code}, 32'd0);
    send_byte(8'h55);
    check("bad_type_err", {30'd0, err_code}, 32'd2);

    // Inter-byte timeout
    fb = {8'hA5, 8'h00};
    send_frame();
    repeat (TO - 1) @(posedge clk_in);
    #1;
    check("timeout_early", {30'd0, err_code}, 32'd0);
    @(posedge clk_in);
    #1;
    check("timeout_err", {30'd0, err_code}, 32'd3);
    random_words(1);
    build_data(8'h01, 16'h0040, 1, 8'h00);
    send_frame();
    compare_writes("after_to");
    check("after_to_err", {30'd0, err_code}, 32'd0);

    // Reset during DATA_LO of the first word
    words = {16'h1122, 16'h3344};
    build_data(8'h00, 16'h0020, 2, 8'h00);
    exp_q = {};
    for (int i = 0; i < 6; i++) send_byte(fb[i]);
    @(negedge clk_in);
    reset_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    repeat (2) @(negedge clk_in);
    reset_n = 1'b1;
    compare_writes("midreset");
    random_words(2);
    build_data(8'h00, 16'h0020, 2, 8'h00);
    send_frame();
    compare_writes("postreset");
    check("postreset_err", {30'd0, err_code}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 5_000_000, is the inter-byte timeout in clk_in cycles (100 ms at 50 MHz).
REQ-002 Parameter SYNC_BYTE, default 8'hA5, is the frame start marker.
REQ-003 clk_in  input  1  the single clock, 50 MHz board clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  the reset; it is asynchronous and active-low.
REQ-005 rx_data  input  8  received byte from the serial receiver.
REQ-006 rx_valid  input  1  rx_data is valid; a byte transfers when rx_valid && rx_ready.
REQ-007 rx_ready  output  1  the loader can accept a byte this cycle.
REQ-008 mem_addr  output  15  word address to program or data RAM.
REQ-009 mem_data  output  16  word to write.
REQ-010 mem_sel  output  1  0 selects program RAM, 1 selects data RAM.
REQ-011 mem_wren  output  1  one-cycle write strobe.
REQ-012 init_out  output  1  drives the core's init input; 1 holds the core in init.
REQ-013 load_done  output  1  pulses for one cycle when a run frame is accepted.
REQ-014 err_code  output  2  sticky error code: 0 none, 1 checksum, 2 format, 3 timeout.

Function
REQ-015 Frame format SHALL be: SYNC, TYPE, ADDR_HI, ADDR_LO, COUNT, then COUNT words sent high byte first, then CHK.
REQ-016 A run frame SHALL be SYNC, 8'hFF, CHK only.
REQ-017 The 8-bit sum of all bytes after SYNC, including CHK, SHALL equal 0 for a frame to be valid.
REQ-018 TYPE SHALL be 8'h00 for program RAM, 8'h01 for data RAM or 8'hFF for run; any other value SHALL give err_code 2 and return the FSM to IDLE.
REQ-019 FSM states SHALL be IDLE, TYPE, ADDR_HI, ADDR_LO, COUNT, DATA_HI, DATA_LO, WRITE, CHECK.
REQ-020 In IDLE, only a SYNC byte SHALL advance to TYPE; all other bytes are discarded silently.
REQ-021 A byte address with bit 0 set, COUNT of 0, or base word + COUNT - 1 > 15'h7FFF SHALL give err_code 2 at the COUNT byte, with no writes issued.
REQ-022 After DATA_LO, the FSM SHALL spend exactly one WRITE cycle with mem_wren=1, mem_addr = base word + index, and rx_ready=0.
REQ-023 rx_ready SHALL be 1 in every state except WRITE.
REQ-024 Words are written as they arrive; a checksum failure SHALL set err_code 1, leave init_out at 1 and return to IDLE; rewriting the frame is the host's job.
REQ-025 A valid run frame SHALL, one cycle after CHK, clear init_out to 0 and pulse load_done.
REQ-026 While init_out=0, an accepted TYPE of 8'h00 or 8'h01 SHALL set init_out back to 1 on the next cycle.
REQ-027 With the FSM outside IDLE, TIMEOUT_CYCLES cycles with no accepted byte SHALL set err_code 3 and return to IDLE.
REQ-028 err_code SHALL hold until the next SYNC byte is accepted in IDLE, which clears it to 0.
REQ-029 An error and an incoming byte in the same cycle: the error SHALL win, and the byte SHALL be consumed by IDLE rules.

Reset
REQ-030 On reset_n=0 the block SHALL immediately enter IDLE with the following values: init_out=1, rx_ready=1, mem_wren=0, mem_addr=0, mem_data=0, mem_sel=0, load_done=0, err_code=0, timer=0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame, with no further writes.

Structure
REQ-032 Package program_loader_pkg SHALL hold the FSM state enum, the TYPE codes, the error codes and the SYNC_BYTE default.
REQ-033 Sub-module inter_byte_timer SHALL implement the timeout counter, with inputs clear and enable and output expired.

Verification
REQ-034 Program load: A5 00 00 10 02 12 34 AB CD then valid CHK -> mem_sel=0 writes 0x1234 at address 0x0008 and 0xABCD at 0x0009; err_code=0; init_out=1.
REQ-035 Run: A5 FF 01 -> init_out falls one cycle after CHK and load_done pulses once.
REQ-036 Bad checksum: a data frame with CHK off by 1 -> its writes still occur, err_code=1, init_out=1; the next A5 clears err_code.
REQ-037 Range: A5 01 FF FE 02 -> err_code=2, no mem_wren, FSM in IDLE.
REQ-038 Timeout: A5 00 then silence for TIMEOUT_CYCLES (set to 100 for the test) -> err_code=3 at cycle 100.
REQ-039 Reset: reset_n pulsed low during DATA_LO of word 1 -> no write; outputs take their reset values; a new frame then loads correctly.
